// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: fetch port, data port, error flag and memory side.
// The arbiter attaches through the slave modport; a requester/memory model uses master.
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_rdata;

  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ready;
  logic [31:0] dm_rdata;

  logic        err;

  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
    output if_ready, if_rdata, dm_ready, dm_rdata, err,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
    input  if_ready, if_rdata, dm_ready, dm_rdata, err,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: an instruction-fetch port and a data port share one
// single-outstanding memory interface. Data normally wins a tie, but a fetch that
// has watched MAX_DM_STREAK data grants go by is granted next. Every access ends
// in a one-cycle response slot; a watchdog aborts accesses the memory never acks.
module mem_arbiter #(
  parameter int MAX_DM_STREAK = 3,
  parameter int TIMEOUT       = 15
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2,
    RESP    = 2'd3
  } state_t;

  localparam int                WDOG_W       = $clog2(TIMEOUT + 1);
  localparam logic [1:0]        STREAK_LIMIT = 2'(MAX_DM_STREAK);
  localparam logic [WDOG_W-1:0] WDOG_LAST    = WDOG_W'(TIMEOUT - 1);

  state_t            state;
  logic [1:0]        dm_streak;
  logic [WDOG_W-1:0] wdog;

  logic              mem_en_r;
  logic              mem_we_r;
  logic [31:0]       mem_addr_r;
  logic [31:0]       mem_wdata_r;

  logic              if_ready_r;
  logic              dm_ready_r;
  logic [31:0]       if_rdata_r;
  logic [31:0]       dm_rdata_r;
  logic              err_r;

  logic              grant_dm;
  logic              grant_if;
  logic              access_done;
  logic [31:0]       resp_data;

  // Streak counter only needs to reach the limit, so it saturates at all-ones.
  function automatic logic [1:0] sat_inc(input logic [1:0] v);
    return (v == 2'b11) ? v : v + 2'd1;
  endfunction

  // Arbitration and completion decisions, consumed only by the FSM below.
  assign grant_dm    = bus.dm_req && !(bus.if_req && (dm_streak == STREAK_LIMIT));
  assign grant_if    = bus.if_req && !grant_dm;
  // An ack on the expiry edge counts as a normal completion.
  assign access_done = bus.mem_ack || (wdog == WDOG_LAST);
  // Writes and aborted accesses return zero data.
  assign resp_data   = (bus.mem_ack && !mem_we_r) ? bus.mem_rdata : 32'd0;

  // Controller: arbitration, memory-side drive, watchdog and response pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      dm_streak   <= 2'd0;
      wdog        <= '0;
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= 32'd0;
      mem_wdata_r <= 32'd0;
      if_ready_r  <= 1'b0;
      dm_ready_r  <= 1'b0;
      if_rdata_r  <= 32'd0;
      dm_rdata_r  <= 32'd0;
      err_r       <= 1'b0;
    end else begin
      if_ready_r <= 1'b0;
      dm_ready_r <= 1'b0;
      if_rdata_r <= 32'd0;
      dm_rdata_r <= 32'd0;
      err_r      <= 1'b0;

      case (state)
        IDLE: begin
          wdog <= '0;
          if (grant_dm) begin
            state       <= BUSY_DM;
            mem_en_r    <= 1'b1;
            mem_we_r    <= bus.dm_we;
            mem_addr_r  <= bus.dm_addr;
            mem_wdata_r <= bus.dm_wdata;
            // Only grants that made a waiting fetch wait extend the streak.
            dm_streak   <= bus.if_req ? sat_inc(dm_streak) : 2'd0;
          end else if (grant_if) begin
            state       <= BUSY_IF;
            mem_en_r    <= 1'b1;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= bus.if_addr;
            mem_wdata_r <= 32'd0;
            dm_streak   <= 2'd0;
          end
        end

        BUSY_IF, BUSY_DM: begin
          // Memory-side registers are not touched here, so they stay stable
          // regardless of what the requesters do while the access is open.
          if (access_done) begin
            state    <= RESP;
            mem_en_r <= 1'b0;
            mem_we_r <= 1'b0;
            wdog     <= '0;
            err_r    <= !bus.mem_ack;
            if (state == BUSY_IF) begin
              if_ready_r <= 1'b1;
              if_rdata_r <= resp_data;
            end else begin
              dm_ready_r <= 1'b1;
              dm_rdata_r <= resp_data;
            end
          end else begin
            wdog <= wdog + 1'b1;
          end
        end

        RESP: begin
          // Response slot: requesters update their request lines here, so no
          // arbitration until the next IDLE cycle.
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_en    = mem_en_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.if_ready  = if_ready_r;
  assign bus.if_rdata  = if_rdata_r;
  assign bus.dm_ready  = dm_ready_r;
  assign bus.dm_rdata  = dm_rdata_r;
  assign bus.err       = err_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed transaction table, multi-cycle corner
// sequences, and a randomized run against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int MAX_DM_STREAK = 3;
  localparam int TIMEOUT       = 15;

  logic clk = 1'b0;
  logic reset;

  mem_arbiter_if bus ();

  mem_arbiter #(
    .MAX_DM_STREAK(MAX_DM_STREAK),
    .TIMEOUT      (TIMEOUT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    bus.if_req    = 1'b0;
    bus.if_addr   = 32'd0;
    bus.dm_req    = 1'b0;
    bus.dm_we     = 1'b0;
    bus.dm_addr   = 32'd0;
    bus.dm_wdata  = 32'd0;
    bus.mem_rdata = 32'd0;
    bus.mem_ack   = 1'b0;
  endtask

  task automatic do_reset(input bit check_out);
    reset = 1'b1;
    idle_inputs();
    @(posedge clk); #1;
    @(posedge clk); #1;
    if (check_out) begin
      chk1 ("rst_mem_en",    bus.mem_en,    1'b0);
      chk1 ("rst_mem_we",    bus.mem_we,    1'b0);
      chk32("rst_mem_addr",  bus.mem_addr,  32'd0);
      chk32("rst_mem_wdata", bus.mem_wdata, 32'd0);
      chk1 ("rst_if_ready",  bus.if_ready,  1'b0);
      chk1 ("rst_dm_ready",  bus.dm_ready,  1'b0);
      chk32("rst_if_rdata",  bus.if_rdata,  32'd0);
      chk32("rst_dm_rdata",  bus.dm_rdata,  32'd0);
      chk1 ("rst_err",       bus.err,       1'b0);
    end
    reset = 1'b0;
  endtask

  // Waits (bounded) for the memory side to become active.
  task automatic wait_en(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(posedge clk); #1;
      if (bus.mem_en) ok = 1'b1;
    end
  endtask

  // Called in the first busy cycle: acks on the delay-th busy edge, returns ready flags.
  task automatic ack_and_wait(input int delay, output bit got_if, output bit got_dm);
    got_if = 1'b0;
    got_dm = 1'b0;
    for (int n = 1; n <= 20 && !(got_if || got_dm); n++) begin
      bus.mem_ack   = (n == delay);
      bus.mem_rdata = 32'h1234_0000 + 32'(n);
      @(posedge clk); #1;
      bus.mem_ack = 1'b0;
      got_if = bus.if_ready;
      got_dm = bus.dm_ready;
    end
  endtask

  typedef struct {
    logic        if_req;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] if_addr;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] rdata;
    int          ack_delay;   // busy edge carrying mem_ack, 0 = never
    logic        exp_dm;      // 1 = data port served, 0 = fetch port
    logic [31:0] exp_addr;
    logic        exp_we;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;     // clock edges from request to ready
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input int idx, input vec_t v);
    int  edges;
    bit  seen;
    bit  stable;
    logic [31:0] got_rdata;
    do_reset(1'b0);
    bus.if_req   = v.if_req;
    bus.if_addr  = v.if_addr;
    bus.dm_req   = v.dm_req;
    bus.dm_we    = v.dm_we;
    bus.dm_addr  = v.dm_addr;
    bus.dm_wdata = v.dm_wdata;
    @(posedge clk); #1;
    edges = 1;
    chk1 ($sformatf("v%0d_grant_en", idx),    bus.mem_en,    1'b1);
    chk32($sformatf("v%0d_grant_addr", idx),  bus.mem_addr,  v.exp_addr);
    chk1 ($sformatf("v%0d_grant_we", idx),    bus.mem_we,    v.exp_we);
    chk32($sformatf("v%0d_grant_wdata", idx), bus.mem_wdata, v.exp_wdata);
    seen   = 1'b0;
    stable = 1'b1;
    while (!seen && edges < 40) begin
      bus.mem_ack   = (edges == v.ack_delay);
      bus.mem_rdata = bus.mem_ack ? v.rdata : $urandom;
      @(posedge clk); #1;
      edges++;
      bus.mem_ack = 1'b0;
      if (bus.if_ready || bus.dm_ready) seen = 1'b1;
      else if (!(bus.mem_en && bus.mem_addr == v.exp_addr && bus.mem_we == v.exp_we &&
                 bus.mem_wdata == v.exp_wdata)) stable = 1'b0;
    end
    got_rdata = v.exp_dm ? bus.dm_rdata : bus.if_rdata;
    chk1 ($sformatf("v%0d_ready_seen", idx), seen,         1'b1);
    chk1 ($sformatf("v%0d_mem_stable", idx), stable,       1'b1);
    chk32($sformatf("v%0d_latency", idx),    32'(edges),   32'(v.exp_lat));
    chk1 ($sformatf("v%0d_if_ready", idx),   bus.if_ready, !v.exp_dm);
    chk1 ($sformatf("v%0d_dm_ready", idx),   bus.dm_ready, v.exp_dm);
    chk32($sformatf("v%0d_rdata", idx),      got_rdata,    v.exp_rdata);
    chk1 ($sformatf("v%0d_err", idx),        bus.err,      v.exp_err);
    chk1 ($sformatf("v%0d_resp_en", idx),    bus.mem_en,   1'b0);
    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;
    @(posedge clk); #1;
    chk1 ($sformatf("v%0d_pulse_end", idx),  bus.if_ready | bus.dm_ready | bus.err, 1'b0);
  endtask

  // Reference model state (transaction level)
  bit          m_busy;
  bit          m_in_resp;
  bit          m_owner_dm;
  int          m_cycles;
  int          m_run;
  int          m_delay;
  logic        e_en, e_we, e_if_ready, e_dm_ready, e_err;
  logic [31:0] e_addr, e_wdata, e_rdata;

  task automatic new_if();
    bus.if_req  = 1'b1;
    bus.if_addr = $urandom;
  endtask

  task automatic new_dm();
    bus.dm_req   = 1'b1;
    bus.dm_we    = 1'($urandom_range(1));
    bus.dm_addr  = $urandom;
    bus.dm_wdata = $urandom;
  endtask

  // Advance the model across the next clock edge using the inputs now driven.
  task automatic model_step();
    e_if_ready = 1'b0;
    e_dm_ready = 1'b0;
    e_err      = 1'b0;
    e_rdata    = 32'd0;
    if (m_busy) begin
      m_cycles++;
      if (bus.mem_ack || m_cycles == TIMEOUT) begin
        m_busy    = 1'b0;
        m_in_resp = 1'b1;
        e_en      = 1'b0;
        e_err     = !bus.mem_ack;
        e_rdata   = (bus.mem_ack && !e_we) ? bus.mem_rdata : 32'd0;
        if (m_owner_dm) e_dm_ready = 1'b1;
        else            e_if_ready = 1'b1;
      end
    end else if (m_in_resp) begin
      m_in_resp = 1'b0;
    end else if (bus.dm_req && !(bus.if_req && m_run == MAX_DM_STREAK)) begin
      m_owner_dm = 1'b1;
      e_addr     = bus.dm_addr;
      e_we       = bus.dm_we;
      e_wdata    = bus.dm_wdata;
      m_run      = bus.if_req ? ((m_run < 3) ? m_run + 1 : 3) : 0;
      m_busy     = 1'b1;
    end else if (bus.if_req) begin
      m_owner_dm = 1'b0;
      e_addr     = bus.if_addr;
      e_we       = 1'b0;
      e_wdata    = 32'd0;
      m_run      = 0;
      m_busy     = 1'b1;
    end
    if (m_busy && m_cycles == 0 && !e_en) begin
      e_en    = 1'b1;
      m_delay = $urandom_range(1, 18);
    end
    if (!m_busy) m_cycles = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    bit ok, gi, gd, who, stable;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 32'h0, 32'h00500093, 1,
                1'b0, 32'h10, 1'b0, 32'h0, 32'h00500093, 1'b0, 2};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h44, 32'h55, 32'hCAFEF00D, 3,
                1'b1, 32'h44, 1'b0, 32'h55, 32'hCAFEF00D, 1'b0, 4};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 32'h0, 32'h100, 32'hDEADBEEF, 32'h11111111, 2,
                1'b1, 32'h100, 1'b1, 32'hDEADBEEF, 32'h0, 1'b0, 3};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h20, 32'h60, 32'h0, 32'hA5A5A5A5, 1,
                1'b1, 32'h60, 1'b0, 32'h0, 32'hA5A5A5A5, 1'b0, 2};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 32'h30, 32'h0, 32'h0, 32'h77777777, 0,
                1'b0, 32'h30, 1'b0, 32'h0, 32'h0, 1'b1, 16};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h70, 32'h0, 32'h0BADF00D, 15,
                1'b1, 32'h70, 1'b0, 32'h0, 32'h0BADF00D, 1'b0, 16};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 32'h0, 32'h90, 32'h12345678, 32'h99999999, 0,
                1'b1, 32'h90, 1'b1, 32'h12345678, 32'h0, 1'b1, 16};

    reset = 1'b1;
    idle_inputs();
    do_reset(1'b1);

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Simultaneous requests: data first, fetch in the IDLE cycle after the data response.
    do_reset(1'b0);
    bus.if_req = 1'b1; bus.if_addr = 32'h40;
    bus.dm_req = 1'b1; bus.dm_addr = 32'h80; bus.dm_we = 1'b0;
    @(posedge clk); #1;
    chk32("simul_first_addr", bus.mem_addr, 32'h80);
    ack_and_wait(2, gi, gd);
    chk1("simul_first_dm_ready", gd, 1'b1);
    bus.dm_req = 1'b0;
    @(posedge clk); #1;
    chk1("simul_idle_en", bus.mem_en, 1'b0);
    @(posedge clk); #1;
    chk1 ("simul_second_en",   bus.mem_en,   1'b1);
    chk32("simul_second_addr", bus.mem_addr, 32'h40);
    ack_and_wait(1, gi, gd);
    chk1("simul_second_if_ready", gi, 1'b1);
    bus.if_req = 1'b0;

    // Starvation: both held, data renewed each time -> D D D F D D D F.
    do_reset(1'b0);
    bus.if_req = 1'b1; bus.if_addr = 32'h2000;
    bus.dm_req = 1'b1; bus.dm_addr = 32'h3000; bus.dm_we = 1'b0;
    for (int g = 0; g < 8; g++) begin
      wait_en(ok);
      if (!ok) begin
        chk1("starve_grant_seen", ok, 1'b1);
        break;
      end
      who = (bus.mem_addr == bus.dm_addr);
      chk1($sformatf("starve_grant%0d_is_dm", g), who, (g % 4) != 3);
      ack_and_wait(1, gi, gd);
      if (gd) bus.dm_addr = bus.dm_addr + 32'd4;
      if (gi) bus.if_addr = bus.if_addr + 32'd4;
    end
    idle_inputs();

    // Request lines changing mid-access leave the memory side untouched.
    do_reset(1'b0);
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h100; bus.dm_wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    bus.dm_addr = 32'hFFFF; bus.dm_wdata = 32'h0; bus.dm_we = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 32'h5;
    stable = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (!(bus.mem_en && bus.mem_we && bus.mem_addr == 32'h100 &&
            bus.mem_wdata == 32'hDEADBEEF)) stable = 1'b0;
    end
    chk1("busy_inputs_ignored", stable, 1'b1);
    ack_and_wait(1, gi, gd);
    chk1 ("busy_write_dm_ready", gd, 1'b1);
    chk32("busy_write_rdata",    bus.dm_rdata, 32'd0);
    idle_inputs();

    // Stray ack while idle produces nothing.
    do_reset(1'b0);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hFACE;
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    @(posedge clk); #1;
    chk1("idle_ack_ignored", bus.if_ready | bus.dm_ready | bus.mem_en | bus.err, 1'b0);

    // Reset mid-access, ack one cycle later: dropped, no ready, back in IDLE.
    do_reset(1'b0);
    bus.dm_req = 1'b1; bus.dm_addr = 32'h200;
    @(posedge clk); #1;
    chk1("rstmid_granted", bus.mem_en, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    bus.dm_req = 1'b0;
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hBEEF;
    chk1("rstmid_en_low", bus.mem_en, 1'b0);
    ok = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      bus.mem_ack = 1'b0;
      if (bus.dm_ready || bus.if_ready || bus.mem_en || bus.err) ok = 1'b0;
    end
    chk1("rstmid_no_pulse", ok, 1'b1);
    bus.if_req = 1'b1; bus.if_addr = 32'h300;
    @(posedge clk); #1;
    chk1 ("rstmid_next_grant_en",   bus.mem_en,   1'b1);
    chk32("rstmid_next_grant_addr", bus.mem_addr, 32'h300);
    ack_and_wait(1, gi, gd);
    chk1("rstmid_next_if_ready", gi, 1'b1);
    idle_inputs();

    // Randomized run against the reference model.
    do_reset(1'b0);
    m_busy = 1'b0; m_in_resp = 1'b0; m_owner_dm = 1'b0;
    m_cycles = 0; m_run = 0; m_delay = 1;
    e_en = 1'b0; e_we = 1'b0; e_addr = 32'd0; e_wdata = 32'd0;
    e_if_ready = 1'b0; e_dm_ready = 1'b0; e_err = 1'b0; e_rdata = 32'd0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (bus.if_req) begin
        if (e_if_ready) begin
          if ($urandom_range(1) == 1) new_if();
          else bus.if_req = 1'b0;
        end
      end else if ($urandom_range(3) == 0) new_if();
      if (bus.dm_req) begin
        if (e_dm_ready) begin
          if ($urandom_range(1) == 1) new_dm();
          else bus.dm_req = 1'b0;
        end
      end else if ($urandom_range(2) == 0) new_dm();
      bus.mem_rdata = $urandom;
      if (m_busy) bus.mem_ack = (m_cycles + 1 == m_delay);
      else        bus.mem_ack = ($urandom_range(7) == 0);
      model_step();
      @(posedge clk); #1;
      chk1("rnd_mem_en", bus.mem_en, e_en);
      if (e_en) begin
        chk32("rnd_mem_addr",  bus.mem_addr,  e_addr);
        chk1 ("rnd_mem_we",    bus.mem_we,    e_we);
        chk32("rnd_mem_wdata", bus.mem_wdata, e_wdata);
      end
      chk1("rnd_if_ready", bus.if_ready, e_if_ready);
      chk1("rnd_dm_ready", bus.dm_ready, e_dm_ready);
      chk1("rnd_err",      bus.err,      e_err);
      if (e_if_ready) chk32("rnd_if_rdata", bus.if_rdata, e_rdata);
      if (e_dm_ready) chk32("rnd_dm_rdata", bus.dm_rdata, e_rdata);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
